// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, states and byte-lane helpers for the data-memory controller
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    RMW_WAIT
  } state_t;

  // Replace the addressed lane(s) of word with the right-aligned bytes of data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8] = data[7:0];
      SZ_HALF: begin
        if (lane[1]) r[31:16] = data[15:0];
        else         r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: r = {{16{sign_ext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM, synchronous read with one-cycle latency, no reset
module dmem_ram #(
  parameter int DEPTH_WORDS = 2048,
  parameter int IDX_W       = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store controller owning the data RAM; sub-word stores by read-modify-write
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          IDX_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  state_t           state;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             fault;

  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             sext_q;
  logic [31:0]      wdata_q;

  logic             ram_we;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  always_comb begin
    off   = addr - BASE_ADDR;
    idx   = off[IDX_W+1:2];
    lane  = off[1:0];
    fault = (off >= LIMIT) || (size == 2'b11) ||
            ((size == SZ_HALF) && lane[0]) ||
            ((size == SZ_WORD) && (lane != 2'b00));
  end

  // Write enable is masked by rst so a reset in RMW_WAIT drops the write-back.
  always_comb begin
    ram_idx   = (state == IDLE) ? idx : idx_q;
    ram_wdata = (state == RMW_WAIT) ? lane_merge(ram_rdata, wdata_q, lane_q, size_q) : wdata;
    ram_we    = !rst && (((state == IDLE) && req && !fault && we && (size == SZ_WORD)) ||
                         (state == RMW_WAIT));
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (fault) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (we && (size == SZ_WORD)) begin
              done <= 1'b1;
            end else begin
              idx_q   <= idx;
              lane_q  <= lane;
              size_q  <= size;
              sext_q  <= sign_ext;
              wdata_q <= wdata;
              busy    <= 1'b1;
              state   <= we ? RMW_WAIT : LD_WAIT;
            end
          end
        end
        LD_WAIT: begin
          rdata <= lane_extract(ram_rdata, lane_q, size_q, sext_q);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        RMW_WAIT: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed and randomized checks against a byte-array memory model
module tb_dmem_access_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int NBYTES = 2048 * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  mb [NBYTES];
  logic [31:0] rdata_m = '0;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .size    (size),
    .sign_ext(sign_ext),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .done    (done),
    .err     (err),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: faults, byte-granular storage, and load value assembled from bytes.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] o;
    logic        flt;
    int          nb;
    int          exp_lat;
    int          lat;
    logic [31:0] v;
    o   = a - BASE;
    flt = (o >= 32'(NBYTES)) || (sz == 2'b11) || (sz == 2'b01 && o[0]) ||
          (sz == 2'b10 && o[1:0] != 2'b00);
    nb  = 1 << sz;
    exp_lat = (flt || (w && sz == 2'b10)) ? 1 : 2;

    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1 && exp_lat == 2) chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
      if (done) begin
        lat = c;
        break;
      end
    end
    req = 1'b0;
    chk({tag, ".lat"}, lat, exp_lat);

    if (!flt) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mb[int'(o) + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mb[int'(o) + i]) << (8 * i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rdata_m = v;
      end
    end
    chk({tag, ".err"}, {31'b0, err}, {31'b0, flt});
    chk({tag, ".rdata"}, rdata, rdata_m);
    chk({tag, ".idle"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, ".pulse"}, {30'b0, done, err}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.flags", {29'b0, done, err, busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) access(1'b1, 2'b10, 1'b0, BASE + 32'(4 * i), $urandom, "init");

    access(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, "sw4");
    access(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, "lw4");
    chk("lw4.val", rdata, 32'hDEAD_BEEF);

    access(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h1122_3344, "sw8");
    access(1'b1, 2'b00, 1'b0, 32'h1001_000A, 32'h0000_00AA, "sbA");
    access(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, "lw8");
    chk("sb.val", rdata, 32'h11AA_3344);
    access(1'b1, 2'b01, 1'b0, 32'h1001_0008, 32'h0000_BEEF, "sh8");
    access(1'b0, 2'b01, 1'b1, 32'h1001_0008, 32'h0, "lh8");
    chk("lh.val", rdata, 32'hFFFF_BEEF);
    access(1'b0, 2'b01, 1'b0, 32'h1001_0008, 32'h0, "lhu8");
    chk("lhu.val", rdata, 32'h0000_BEEF);

    access(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h8000_0000, "sw8b");
    access(1'b0, 2'b00, 1'b1, 32'h1001_000B, 32'h0, "lbB");
    chk("lb.val", rdata, 32'hFFFF_FF80);
    access(1'b0, 2'b00, 1'b0, 32'h1001_000B, 32'h0, "lbuB");
    chk("lbu.val", rdata, 32'h0000_0080);

    access(1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h1234_5678, "sh_mis");
    access(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, "lw_mis");
    access(1'b1, 2'b10, 1'b0, 32'h1001_2000, 32'h1234_5678, "sw_oor");
    access(1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0, "lw_below");
    access(1'b1, 2'b11, 1'b0, 32'h1001_0000, 32'h1234_5678, "sz_ill");
    access(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, "lw0");
    access(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, "lw4b");

    // Reset while the sub-word store is between read and write-back.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h1001_000C; wdata = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_rst.busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("rmw_rst.flags", {29'b0, done, err, busy}, 32'd0);
    chk("rmw_rst.rdata", rdata, 32'd0);
    rst = 1'b0;
    rdata_m = '0;
    @(negedge clk);
    access(1'b0, 2'b10, 1'b0, 32'h1001_000C, 32'h0, "rmw_rst.word");
    access(1'b1, 2'b00, 1'b0, 32'h1001_000D, 32'h0000_0077, "sb_after");
    access(1'b0, 2'b10, 1'b0, 32'h1001_000C, 32'h0, "lw_after");

    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (sel == 1) a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 64));
      else               a = BASE + 32'($urandom_range(0, 63));
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory access controller directly downstream of the store-data merge logic. Owns the word-wide data RAM.
- Executes lw/lh/lhu/lb/lbu loads and sw/sh/sb stores.
- Sub-word stores are done by read-modify-write: read the word, merge the lane, write the word back.
- Asserts busy so the CPU pipeline stalls; pulses done when the access retires.

Parameters:
- BASE_ADDR, 32'h10010000, byte address mapped to RAM word 0.
- DEPTH_WORDS, 2048, RAM depth in 32-bit words.
- IDX_W, 11, word-index width; must equal clog2(DEPTH_WORDS).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; the active bytes are right-aligned.
- rdata  out  32  load result; held until the next load retires.
- done  out  1  one-cycle pulse when an access retires.
- err  out  1  qualifies done: misaligned, out-of-range or illegal size.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: rdata=0, done=0, err=0, busy=0, state=IDLE. RAM contents are not cleared.
- Reset during any state: return to IDLE and drop the pending write-back. The RAM is untouched unless the write edge has already occurred.
- Address decode:
  - off = addr - BASE_ADDR (32-bit subtract); idx = off[IDX_W+1:2]; lane = off[1:0].
  - Out of range when off >= DEPTH_WORDS*4. Addresses below BASE_ADDR wrap to large off values and are therefore out of range.
- Fault check:
  - Misaligned: half with lane[0]=1; word with lane!=0.
  - size=11 is illegal.
  - Any fault: no RAM access, go to IDLE, done=1 and err=1 in the next cycle, rdata unchanged.
- Byte order is little-endian:
  - lane 0 → bits [7:0], lane 3 → bits [31:24].
  - Half at lane 0 → [15:0]; half at lane 2 → [31:16].
- RAM: single port, synchronous read, 1-cycle latency, write on the edge when its write enable is high.
- States: IDLE, LD_WAIT, RMW_WAIT.
- IDLE with req=1 and no fault:
  - sw: write wdata to RAM[idx] on edge E0; stay in IDLE; done=1 in the cycle after E0 (latency 1).
  - Load: issue read at E0, go to LD_WAIT. At E1, register the extracted and extended lane into rdata, set done=1, go to IDLE (latency 2).
  - sb/sh: issue read at E0, go to RMW_WAIT. At E1, write the merged word (the other bytes come from the read data), set done=1, go to IDLE (latency 2).
- req while busy is ignored; the CPU holds req and the request fields stable until done.
- A new req may be accepted in the same cycle done is high; back-to-back accesses are allowed.
- done and err are registered and clear after one cycle. err is 0 on every non-fault done.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum.
  - BASE_ADDR default.
  - lane_merge(word, data, lane, size) function.
  - lane_extract(word, lane, size, sign_ext) function.
- Sub-module dmem_ram: DEPTH_WORDS x 32, synchronous read, 1-cycle latency, no reset.

Test Plan:
- sw 32'hDEADBEEF @10010004, then lw @10010004 → sw done 1 cycle after accept with err=0; lw rdata=DEADBEEF 2 cycles after accept.
- Word at 10010008 = 11223344; sb wdata=000000AA @1001000A; lw → rdata=11AA3344.
- Same word; sh wdata=0000BEEF @10010008 then lh @10010008 → rdata=FFFFBEEF; lhu → rdata=0000BEEF.
- Word = 80000000; lb @1001000B → rdata=FFFFFF80; lbu → rdata=00000080.
- sh @10010001, lw @10010002, and sw @10012000 (DEPTH 2048) → each gives done=1, err=1, no RAM change, rdata unchanged.
- rst pulsed while in RMW_WAIT during sb → busy=0 next cycle, no done, RAM word unchanged; then sb 2 cycles after rst drops proceeds normally.
